// File: rtl/mips_pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding logic: slot record,
// bubble constant and the per-cycle pipeline mode.
package mips_pipe_pkg;

    localparam int REG_W = 5;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } slot_t;

    localparam slot_t BUBBLE_SLOT = '0;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_FREEZE,
        MODE_FLUSH,
        MODE_STALL
    } mode_e;

    // A slot is a forwarding source only if it really writes a non-zero register.
    function automatic logic fwd_valid(slot_t s);
        return s.valid & s.reg_write & (s.rd != '0);
    endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// ID-stage request signals and the control/forwarding results of the hazard tracker.
interface hazard_tracker_if #(
    parameter int CNT_W = 16
);
    import mips_pipe_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             branch_taken;
    logic             dmem_busy;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             mem_reg_write;
    logic [REG_W-1:0] mem_rd;
    logic             wb_reg_write;
    logic [REG_W-1:0] wb_rd;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read,
               branch_taken, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               mem_reg_write, mem_rd, wb_reg_write, wb_rd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write, id_mem_read,
               branch_taken, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               mem_reg_write, mem_rd, wb_reg_write, wb_rd, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_slot_reg.sv
// One in-flight instruction slot: clear (bubble) beats load, otherwise hold.
module hazard_slot_reg
    import mips_pipe_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  i_load,
    input  logic  i_clear,
    input  slot_t i_d,
    output slot_t o_q
);

    slot_t r_q;

    // NOTE: clocked state uses <= so every slot samples its pre-edge neighbour,
    // which is what lets EX->MEM->WB shift in a single edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_q <= BUBBLE_SLOT;
        end else if (i_clear) begin
            r_q <= BUBBLE_SLOT;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_tracker.sv
// Tracks EX/MEM/WB destinations, drives forwarding pairs and resolves
// freeze > flush > load-use stall > run each cycle.
module hazard_tracker
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_tracker_if.slave  bus
);

    slot_t            w_id_slot;
    slot_t            w_ex;
    slot_t            w_mem;
    slot_t            w_wb;
    mode_e            w_mode;
    logic             w_lu;
    logic             w_advance;
    logic             w_ex_load;
    logic             w_ex_clear;
    logic             w_unused;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_id_slot = '{valid:     bus.id_valid,
                         rd:        bus.id_rd,
                         reg_write: bus.id_reg_write,
                         mem_read:  bus.id_mem_read};

    assign w_lu = bus.id_valid & w_ex.valid & w_ex.mem_read & (w_ex.rd != '0) &
                  ((w_ex.rd == bus.id_rs) | (bus.id_uses_rt & (w_ex.rd == bus.id_rt)));

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_mode = MODE_RUN;
        if (!rst_i) begin
            w_mode = MODE_RUN;
        end else if (bus.dmem_busy) begin
            w_mode = MODE_FREEZE;
        end else if (bus.branch_taken) begin
            w_mode = MODE_FLUSH;
        end else if (w_lu) begin
            w_mode = MODE_STALL;
        end
    end

    assign w_advance  = (w_mode != MODE_FREEZE);
    assign w_ex_load  = (w_mode == MODE_RUN);
    assign w_ex_clear = (w_mode == MODE_FLUSH) || (w_mode == MODE_STALL);

    hazard_slot_reg u_ex_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_ex_load),
        .i_clear (w_ex_clear),
        .i_d     (w_id_slot),
        .o_q     (w_ex)
    );

    hazard_slot_reg u_mem_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_advance),
        .i_clear (1'b0),
        .i_d     (w_ex),
        .o_q     (w_mem)
    );

    hazard_slot_reg u_wb_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_advance),
        .i_clear (1'b0),
        .i_d     (w_mem),
        .o_q     (w_wb)
    );

    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        unique case (w_mode)
            MODE_FREEZE: begin
                bus.pc_write    = 1'b0;
                bus.if_id_write = 1'b0;
            end
            MODE_FLUSH: begin
                bus.if_id_flush  = 1'b1;
                bus.id_ex_bubble = 1'b1;
            end
            MODE_STALL: begin
                bus.pc_write     = 1'b0;
                bus.if_id_write  = 1'b0;
                bus.id_ex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    // Performance counters saturate instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_mode == MODE_STALL) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((w_mode == MODE_FLUSH) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.mem_reg_write = fwd_valid(w_mem);
    assign bus.mem_rd        = w_mem.rd;
    assign bus.wb_reg_write  = fwd_valid(w_wb);
    assign bus.wb_rd         = w_wb.rd;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;

    // The load flag is dead once an instruction reaches WB.
    assign w_unused = w_wb.mem_read;

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: a vector table plus hand-written freeze, flush
// and reset-mid-stall sequences, checked through an expected-value queue.
module tb_hazard_tracker;
    import mips_pipe_pkg::*;

    typedef struct {
        logic             v;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             urt;
        logic [REG_W-1:0] rd;
        logic             rw;
        logic             mr;
        logic             br;
        logic             busy;
    } in_t;

    typedef struct {
        logic             pc;
        logic             ifw;
        logic             fl;
        logic             bub;
        logic             mrw;
        logic [REG_W-1:0] mrd;
        logic             wrw;
        logic [REG_W-1:0] wrd;
        logic [15:0]      sc;
        logic [15:0]      fc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic   clk_i = 1'b0;
    logic   rst_i = 1'b0;
    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   exp_q[$];
    vec_t   vecs[18];

    hazard_tracker_if #(.CNT_W(16)) bus ();

    hazard_tracker #(.CNT_W(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic in_t ins(logic v, int rs, int rt, logic urt, int rd,
                                logic rw, logic mr, logic br, logic busy);
        in_t t;
        t.v = v; t.rs = REG_W'(rs); t.rt = REG_W'(rt); t.urt = urt; t.rd = REG_W'(rd);
        t.rw = rw; t.mr = mr; t.br = br; t.busy = busy;
        return t;
    endfunction

    function automatic in_t idle();
        return ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic in_t lw(int rd);
        return ins(1, 1, 0, 0, rd, 1, 1, 0, 0);
    endfunction

    function automatic in_t alu(int rs, int rt, int rd);
        return ins(1, rs, rt, 1, rd, 1, 0, 0, 0);
    endfunction

    function automatic exp_t ex(logic pc, logic ifw, logic fl, logic bub, logic mrw, int mrd,
                                logic wrw, int wrd, int sc, int fc);
        exp_t e;
        e.pc = pc; e.ifw = ifw; e.fl = fl; e.bub = bub;
        e.mrw = mrw; e.mrd = REG_W'(mrd); e.wrw = wrw; e.wrd = REG_W'(wrd);
        e.sc = 16'(sc); e.fc = 16'(fc);
        return e;
    endfunction

    function automatic exp_t run(logic mrw, int mrd, logic wrw, int wrd, int sc, int fc);
        return ex(1, 1, 0, 0, mrw, mrd, wrw, wrd, sc, fc);
    endfunction

    function automatic exp_t stall(logic mrw, int mrd, logic wrw, int wrd, int sc, int fc);
        return ex(0, 0, 0, 1, mrw, mrd, wrw, wrd, sc, fc);
    endfunction

    function automatic vec_t mk(in_t i, exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic drive(in_t t);
        bus.id_valid     = t.v;
        bus.id_rs        = t.rs;
        bus.id_rt        = t.rt;
        bus.id_uses_rt   = t.urt;
        bus.id_rd        = t.rd;
        bus.id_reg_write = t.rw;
        bus.id_mem_read  = t.mr;
        bus.branch_taken = t.br;
        bus.dmem_busy    = t.busy;
    endtask

    task automatic sample(string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".pc_write"},      32'(bus.pc_write),      32'(e.pc));
        check({tag, ".if_id_write"},   32'(bus.if_id_write),   32'(e.ifw));
        check({tag, ".if_id_flush"},   32'(bus.if_id_flush),   32'(e.fl));
        check({tag, ".id_ex_bubble"},  32'(bus.id_ex_bubble),  32'(e.bub));
        check({tag, ".mem_reg_write"}, 32'(bus.mem_reg_write), 32'(e.mrw));
        check({tag, ".mem_rd"},        32'(bus.mem_rd),        32'(e.mrd));
        check({tag, ".wb_reg_write"},  32'(bus.wb_reg_write),  32'(e.wrw));
        check({tag, ".wb_rd"},         32'(bus.wb_rd),         32'(e.wrd));
        check({tag, ".stall_cnt"},     32'(bus.stall_cnt),     32'(e.sc));
        check({tag, ".flush_cnt"},     32'(bus.flush_cnt),     32'(e.fc));
    endtask

    task automatic apply(vec_t v, string tag);
        drive(v.i);
        exp_q.push_back(v.e);
        @(negedge clk_i);
        sample(tag);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        drive(idle());
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Load-use via rs, forwarding chain, $0 writer/reader, uses_rt gating, load-use via rt.
        vecs[0]  = mk(idle(),                         run(0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(lw(2),                          run(0, 0, 0, 0, 0, 0));
        vecs[2]  = mk(alu(2, 3, 4),                   stall(0, 0, 0, 0, 0, 0));
        vecs[3]  = mk(alu(2, 3, 4),                   run(1, 2, 0, 0, 1, 0));
        vecs[4]  = mk(alu(1, 1, 3),                   run(0, 0, 1, 2, 1, 0));
        vecs[5]  = mk(alu(3, 2, 6),                   run(1, 4, 0, 0, 1, 0));
        vecs[6]  = mk(idle(),                         run(1, 3, 1, 4, 1, 0));
        vecs[7]  = mk(lw(0),                          run(1, 6, 1, 3, 1, 0));
        vecs[8]  = mk(alu(0, 0, 7),                   run(0, 0, 1, 6, 1, 0));
        vecs[9]  = mk(idle(),                         run(0, 0, 0, 0, 1, 0));
        vecs[10] = mk(idle(),                         run(1, 7, 0, 0, 1, 0));
        vecs[11] = mk(idle(),                         run(0, 0, 1, 7, 1, 0));
        vecs[12] = mk(lw(5),                          run(0, 0, 0, 0, 1, 0));
        vecs[13] = mk(ins(1, 1, 5, 0, 0, 0, 0, 0, 0), run(0, 0, 0, 0, 1, 0));
        vecs[14] = mk(lw(8),                          run(1, 5, 0, 0, 1, 0));
        vecs[15] = mk(alu(1, 8, 9),                   stall(0, 0, 1, 5, 1, 0));
        vecs[16] = mk(alu(1, 8, 9),                   run(1, 8, 0, 0, 2, 0));
        vecs[17] = mk(idle(),                         run(0, 0, 1, 8, 2, 0));

        drive(idle());
        rst_i = 1'b0;
        exp_q.push_back(run(0, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        sample("reset");
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int k = 0; k < 18; k++) begin
            apply(vecs[k], $sformatf("vec%0d", k));
        end

        // Branch and load-use in the same cycle: the flush wins.
        do_reset();
        apply(mk(lw(2),                          run(0, 0, 0, 0, 0, 0)),             "br_lw");
        apply(mk(ins(1, 2, 3, 1, 4, 1, 0, 1, 0), ex(1, 1, 1, 1, 0, 0, 0, 0, 0, 0)), "br_flush");
        apply(mk(idle(),                         run(1, 2, 0, 0, 0, 1)),             "br_after1");
        apply(mk(idle(),                         run(0, 0, 1, 2, 0, 1)),             "br_after2");

        // Freeze for three cycles over a pending load-use (one also has a branch).
        do_reset();
        apply(mk(lw(2),                          run(0, 0, 0, 0, 0, 0)),             "fz_lw");
        apply(mk(ins(1, 2, 3, 1, 4, 1, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "fz_busy1");
        apply(mk(ins(1, 2, 3, 1, 4, 1, 0, 1, 1), ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "fz_busy2");
        apply(mk(ins(1, 2, 3, 1, 4, 1, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), "fz_busy3");
        apply(mk(alu(2, 3, 4),                   stall(0, 0, 0, 0, 0, 0)),           "fz_stall");
        apply(mk(alu(2, 3, 4),                   run(1, 2, 0, 0, 1, 0)),             "fz_run");

        // Fill all three slots, then reset in the middle of a load-use stall.
        apply(mk(lw(2),                          run(0, 0, 1, 2, 1, 0)),             "rs_lw2");
        apply(mk(lw(3),                          run(1, 4, 0, 0, 1, 0)),             "rs_lw3");
        apply(mk(lw(4),                          run(1, 2, 1, 4, 1, 0)),             "rs_lw4");
        drive(alu(4, 5, 6));
        exp_q.push_back(stall(1, 3, 1, 2, 1, 0));
        @(negedge clk_i);
        sample("rs_stall");
        #1;
        rst_i = 1'b0;
        exp_q.push_back(run(0, 0, 0, 0, 0, 0));
        #1;
        sample("rs_async");
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        apply(mk(alu(4, 5, 6),                   run(0, 0, 0, 0, 0, 0)),             "rs_first_run");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer side of the pipeline forwarding interface. Tracks the destination register, write-enable and load flag of every in-flight instruction in the EX, MEM and WB slots.
- Drives the MEM-stage and WB-stage (control, rd) pairs that the forwarding unit consumes.
- Generates load-use stalls, branch flushes and data-memory-wait freezes for the 5-stage MIPS pipeline.
- Sits beside the ID stage and is clocked with the pipeline registers.

Parameters:
- REG_W, 5, register-address width
- CNT_W, 16, width of the stall/flush performance counters

Ports:
- clk_i  in  1  pipeline clock
- rst_i  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_W  ID source register rs
- id_rt  in  REG_W  ID source register rt
- id_uses_rt  in  1  ID instruction reads rt
- id_rd  in  REG_W  ID destination register (already muxed rt/rd)
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- branch_taken  in  1  branch resolved taken in EX this cycle
- dmem_busy  in  1  data memory not ready; freeze the whole pipeline
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  zero the IF/ID register
- id_ex_bubble  out  1  load a NOP into ID/EX
- mem_reg_write  out  1  forwarding: MEM slot writes a register
- mem_rd  out  REG_W  forwarding: MEM slot destination
- wb_reg_write  out  1  forwarding: WB slot writes a register
- wb_rd  out  REG_W  forwarding: WB slot destination
- stall_cnt  out  CNT_W  load-use stall cycles since reset
- flush_cnt  out  CNT_W  branch flushes since reset

Behaviour:
Interface decision:
- One clock, clk_i. Reset rst_i is asynchronous and active-low.

Slots:
- Three slot registers EX, MEM and WB. Each holds {valid, rd, reg_write, mem_read}.
- Reset: all slots cleared. All counters 0. State RUN.
- Reset output values: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, mem_reg_write=0, mem_rd=0, wb_reg_write=0, wb_rd=0.
- Forwarding outputs are registered slot contents, not combinational from the ID inputs:
  - mem_reg_write = MEM.valid & MEM.reg_write & (MEM.rd != 0); mem_rd = MEM.rd.
  - wb_reg_write and wb_rd follow the same rule using the WB slot.
- Load-use hazard (LU), combinational: id_valid & EX.valid & EX.mem_read & EX.rd != 0 & (EX.rd == id_rs | (id_uses_rt & EX.rd == id_rt)).

Per-cycle priority:
1. dmem_busy=1 (FREEZE):
   - All slots hold. pc_write=0, if_id_write=0, flush=0, bubble=0. Counters hold.
   - branch_taken and LU are re-evaluated after the freeze, because EX is held.
2. branch_taken=1 (FLUSH):
   - EX→MEM, MEM→WB. EX slot loaded with an invalid bubble; ID content is discarded.
   - if_id_flush=1, id_ex_bubble=1, pc_write=1 (target fetch). flush_cnt += 1.
   - LU in the same cycle is ignored.
3. LU=1 (STALL):
   - pc_write=0, if_id_write=0, id_ex_bubble=1.
   - EX→MEM, MEM→WB. EX slot becomes invalid. stall_cnt += 1.
   - The next cycle re-checks; LU is now false, so the stall lasts exactly 1 cycle per load.
4. Otherwise (RUN):
   - ID fields→EX (valid = id_valid), EX→MEM, MEM→WB.
   - pc_write=1, if_id_write=1, all other controls 0.

Control outputs:
- Combinational from the current slots and inputs. Latency 0 for control.
- Forwarding pairs appear 1 cycle after an instruction leaves EX (MEM view) and 2 cycles after (WB view).

Counters:
- Saturate at all-ones; no wrap.

Reset mid-operation:
- Asserting rst_i clears all slots and counters immediately, mid-stall or mid-freeze. The first cycle after release is RUN.

Register $0:
- Never reported as a forwarding source or a hazard.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - REG_W
  - slot struct {valid, rd, reg_write, mem_read}
  - BUBBLE_SLOT constant (all zeros)
- One natural sub-module, hazard_slot_reg: a single slot register with hold/load/clear controls, instantiated three times. Priority logic and counters live in the top level.

Test Plan:
- Load-use: lw $2 enters EX, ID add reads rs=$2 → pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle. stall_cnt=1. Next cycle mem_reg_write=1, mem_rd=2.
- Forwarding path: add $3 then sub with rs=$3, no load → no stall. mem_rd=3 one cycle after add leaves EX, wb_rd=3 the cycle after.
- Register $0: lw writing $0 followed by a reader of $0 → no stall; mem_reg_write stays 0.
- Branch plus load-use same cycle: branch_taken=1 and LU=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1. flush_cnt=1, stall_cnt unchanged.
- Freeze: dmem_busy high for 3 cycles during a load-use → outputs pc_write=0, slots unchanged, counters unchanged. The stall executes on the first cycle after busy drops.
- Reset during a stall: drop rst_i mid-stall → all outputs return to reset values asynchronously. stall_cnt=0, wb_reg_write=0.
